delay_monitor: RTL and testbench

Receive-side checker for the periodic `sig` pulse produced by the delay counter. Measures the interval between successive `sig` pulses and compares it against the expected period. Reports early and late pulses and declares lock after a run of good intervals. Sits at the consumer end of the delay pulse path and feeds the top-level error aggregation.

---
 rtl/delay_pkg.sv | 21 ++
 rtl/delay_ivl_cnt.sv | 33 +++
 rtl/delay_monitor.sv | 130 +++++++++++++
 tb/tb_delay_monitor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types and constants for the delay pulse monitor.
// Build option DELAY_MON_TOL_EN (used by delay_monitor) widens the acceptance window by +/-TOL.
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } dly_state_e;

  localparam int DLY_PERIOD = 5001;
  localparam int DLY_CBITS  = 13;

  // The counter must be able to hold U+1 without saturating early.
  function automatic bit dly_cbits_ok(input int cbits, input int period, input int tol);
    longint max_cnt;
    max_cnt = (longint'(1) << cbits) - longint'(1);
    return max_cnt >= longint'(period + tol + 1);
  endfunction

endpackage

// File: rtl/delay_ivl_cnt.sv
// Saturating interval counter: reloads to 1 on a pulse, otherwise counts up and sticks at all-ones.
module delay_ivl_cnt #(
  parameter int CBITS = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  output logic [CBITS-1:0] ivl_o
);

  logic [CBITS-1:0] ivl_q;
  logic [CBITS-1:0] ivl_d;

  always_comb begin
    ivl_d = ivl_q;
    if (load_i) begin
      ivl_d = CBITS'(1);
    end else if (ivl_q != {CBITS{1'b1}}) begin
      ivl_d = ivl_q + CBITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ivl_q <= '0;
    end else begin
      ivl_q <= ivl_d;
    end
  end

  assign ivl_o = ivl_q;

endmodule

// File: rtl/delay_monitor.sv
// Checks the spacing of periodic sig pulses, flags early/late arrivals and declares lock.
// Define DELAY_MON_TOL_EN to accept intervals in [PERIOD-TOL, PERIOD+TOL] instead of exactly PERIOD.
module delay_monitor
  import delay_pkg::*;
#(
  parameter int PERIOD   = DLY_PERIOD,
  parameter int CBITS    = DLY_CBITS,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  output logic             locked,
  output logic             early,
  output logic             late,
  output logic             good,
  output logic             err,
  output logic [CBITS-1:0] last_ivl
);

`ifdef DELAY_MON_TOL_EN
  localparam int LO = PERIOD - TOL;
  localparam int HI = PERIOD + TOL;
`else
  localparam int LO = PERIOD;
  localparam int HI = PERIOD;
`endif
  localparam logic [CBITS-1:0] LO_C   = CBITS'(LO);
  localparam logic [CBITS-1:0] LATE_C = CBITS'(HI + 1);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_CNT);

  if (!dly_cbits_ok(CBITS, PERIOD, TOL)) begin : g_cbits_check
    $error("delay_monitor: CBITS too narrow for PERIOD+TOL+1");
  end

  dly_state_e       state_q;
  logic [3:0]       run_q;
  logic             sig_q;
  logic             locked_q;
  logic             early_q;
  logic             late_q;
  logic             good_q;
  logic             err_q;
  logic [CBITS-1:0] last_ivl_q;
  logic [CBITS-1:0] ivl;

  delay_ivl_cnt #(
    .CBITS (CBITS)
  ) u_ivl_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (sig_q),
    .ivl_o  (ivl)
  );

  // sig is registered first; the FSM and counter both act on sig_q, giving one cycle of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      run_q      <= '0;
      sig_q      <= 1'b0;
      locked_q   <= 1'b0;
      early_q    <= 1'b0;
      late_q     <= 1'b0;
      good_q     <= 1'b0;
      err_q      <= 1'b0;
      last_ivl_q <= '0;
    end else begin
      sig_q   <= sig;
      early_q <= 1'b0;
      late_q  <= 1'b0;
      good_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sig_q) begin
            state_q <= ACQ;
            run_q   <= '0;
          end
        end
        ACQ, LOCKED: begin
          if (ivl == LATE_C) begin
            // Timeout wins over a coincident pulse, which then serves as the new reference.
            late_q   <= 1'b1;
            run_q    <= '0;
            locked_q <= 1'b0;
            if (state_q == LOCKED) err_q <= 1'b1;
            if (sig_q) begin
              state_q    <= ACQ;
              last_ivl_q <= ivl;
            end else begin
              state_q <= IDLE;
            end
          end else if (sig_q) begin
            last_ivl_q <= ivl;
            if (ivl < LO_C) begin
              early_q  <= 1'b1;
              run_q    <= '0;
              locked_q <= 1'b0;
              state_q  <= ACQ;
              if (state_q == LOCKED) err_q <= 1'b1;
            end else begin
              good_q <= 1'b1;
              if (state_q == ACQ) begin
                run_q <= run_q + 4'd1;
                if (run_q + 4'd1 == LOCK_C) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          run_q    <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked   = locked_q;
  assign early    = early_q;
  assign late     = late_q;
  assign good     = good_q;
  assign err      = err_q;
  assign last_ivl = last_ivl_q;

endmodule

// File: tb/tb_delay_monitor.sv
// Directed bench for delay_monitor with PERIOD=8, TOL=1, LOCK_CNT=3; adapts to DELAY_MON_TOL_EN.
module tb_delay_monitor;
  import delay_pkg::*;

  localparam int PERIOD   = 8;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 3;
  localparam int CBITS    = 13;
`ifdef DELAY_MON_TOL_EN
  localparam int LATE_AT = 10;
`else
  localparam int LATE_AT = 9;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sig = 1'b0;
  logic             locked;
  logic             early;
  logic             late;
  logic             good;
  logic             err;
  logic [CBITS-1:0] last_ivl;
  logic [4:0]       flags;

  int checks = 0;
  int errors = 0;

  delay_monitor #(
    .PERIOD   (PERIOD),
    .CBITS    (CBITS),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig      (sig),
    .locked   (locked),
    .early    (early),
    .late     (late),
    .good     (good),
    .err      (err),
    .last_ivl (last_ivl)
  );

  always #5 clk = ~clk;

  // flags = {locked, early, late, good, err}
  assign flags = {locked, early, late, good, err};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse, then stop just after the edge where its strobes become visible.
  task automatic send_first;
    sig = 1'b1;
    tick();
    sig = 1'b0;
    tick();
    $display("pulse first flags=%b last_ivl=%0d", flags, last_ivl);
  endtask

  // Next pulse lands gap cycles after the previous one; returns with its strobes visible.
  task automatic send(input int gap);
    repeat (gap - 2) begin
      sig = 1'b0;
      tick();
    end
    sig = 1'b1;
    tick();
    sig = 1'b0;
    tick();
    $display("pulse gap=%0d flags=%b last_ivl=%0d", gap, flags, last_ivl);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (flags !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", flags);
    end
    checks++;
    if (last_ivl !== 13'd0) begin
      errors++;
      $display("FAIL reset_last_ivl got %0d want 0", last_ivl);
    end
    checks++;
    if (dut.ivl !== 13'd0 || dut.run_q !== 4'd0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_internal got ivl=%0d run=%0d state=%0d want 0 0 IDLE",
               dut.ivl, dut.run_q, dut.state_q);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_lock;
    send_first();
    checks++;
    if (flags !== 5'b00000 || dut.state_q !== ACQ) begin
      errors++;
      $display("FAIL lock_ref got flags=%b state=%0d want 00000 ACQ", flags, dut.state_q);
    end
    for (int i = 1; i <= 3; i++) begin
      send(8);
      checks++;
      if (flags !== ((i == 3) ? 5'b10010 : 5'b00010) || last_ivl !== 13'd8) begin
        errors++;
        $display("FAIL lock_good%0d got flags=%b last_ivl=%0d want %b 8",
                 i, flags, last_ivl, (i == 3) ? 5'b10010 : 5'b00010);
      end
    end
  endtask

  task automatic test_early;
    send(5);
    checks++;
    if (flags !== 5'b01001 || last_ivl !== 13'd5 || dut.state_q !== ACQ) begin
      errors++;
      $display("FAIL early_hit got flags=%b last_ivl=%0d state=%0d want 01001 5 ACQ",
               flags, last_ivl, dut.state_q);
    end
    for (int i = 1; i <= 3; i++) begin
      send(8);
      checks++;
      if (flags !== ((i == 3) ? 5'b10011 : 5'b00011)) begin
        errors++;
        $display("FAIL early_relock%0d got flags=%b want %b",
                 i, flags, (i == 3) ? 5'b10011 : 5'b00011);
      end
    end
  endtask

  task automatic test_late;
    int wraps;
    int stray;
    logic [CBITS-1:0] prev;
    sig = 1'b0;
    for (int c = 1; c <= LATE_AT + 1; c++) begin
      tick();
      checks++;
      if (late !== (c == LATE_AT)) begin
        errors++;
        $display("FAIL late_timing cycle %0d got late=%b want %b", c, late, c == LATE_AT);
      end
    end
    $display("gap late_at=%0d flags=%b", LATE_AT, flags);
    checks++;
    if (flags !== 5'b00001 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL late_state got flags=%b state=%0d want 00001 IDLE", flags, dut.state_q);
    end
    wraps = 0;
    stray = 0;
    prev  = dut.ivl;
    repeat (9000) begin
      tick();
      if (dut.ivl < prev) wraps++;
      if (late) stray++;
      prev = dut.ivl;
    end
    $display("long gap ivl=%0d", dut.ivl);
    checks++;
    if (wraps !== 0 || stray !== 0) begin
      errors++;
      $display("FAIL late_gap got wraps=%0d stray_late=%0d want 0 0", wraps, stray);
    end
    checks++;
    if (dut.ivl !== 13'h1FFF) begin
      errors++;
      $display("FAIL late_saturate got ivl=%0d want 8191", dut.ivl);
    end
  endtask

  task automatic test_window;
    send_first();
    checks++;
    if (flags !== 5'b00001 || dut.state_q !== ACQ) begin
      errors++;
      $display("FAIL window_ref got flags=%b state=%0d want 00001 ACQ", flags, dut.state_q);
    end
`ifdef DELAY_MON_TOL_EN
    send(7);
    checks++;
    if (flags !== 5'b00011 || last_ivl !== 13'd7) begin
      errors++;
      $display("FAIL window_7 got flags=%b last_ivl=%0d want 00011 7", flags, last_ivl);
    end
    send(9);
    checks++;
    if (flags !== 5'b00011 || last_ivl !== 13'd9) begin
      errors++;
      $display("FAIL window_9 got flags=%b last_ivl=%0d want 00011 9", flags, last_ivl);
    end
    send(8);
    checks++;
    if (flags !== 5'b10011 || last_ivl !== 13'd8) begin
      errors++;
      $display("FAIL window_8 got flags=%b last_ivl=%0d want 10011 8", flags, last_ivl);
    end
`else
    send(7);
    checks++;
    if (flags !== 5'b01001 || last_ivl !== 13'd7 || dut.state_q !== ACQ) begin
      errors++;
      $display("FAIL window_7 got flags=%b last_ivl=%0d want 01001 7", flags, last_ivl);
    end
    send(9);
    checks++;
    if (flags !== 5'b00101 || last_ivl !== 13'd9 || dut.state_q !== ACQ) begin
      errors++;
      $display("FAIL window_9 got flags=%b last_ivl=%0d state=%0d want 00101 9 ACQ",
               flags, last_ivl, dut.state_q);
    end
    send(8);
    checks++;
    if (flags !== 5'b00011 || dut.run_q !== 4'd1) begin
      errors++;
      $display("FAIL window_8 got flags=%b run=%0d want 00011 1", flags, dut.run_q);
    end
`endif
  endtask

  task automatic test_boundary;
    send(LATE_AT);
    checks++;
    if (flags !== 5'b00101 || dut.state_q !== ACQ || dut.run_q !== 4'd0) begin
      errors++;
      $display("FAIL boundary_late got flags=%b state=%0d run=%0d want 00101 ACQ 0",
               flags, dut.state_q, dut.run_q);
    end
    checks++;
    if (last_ivl !== 13'(LATE_AT)) begin
      errors++;
      $display("FAIL boundary_ivl got %0d want %0d", last_ivl, LATE_AT);
    end
    for (int i = 1; i <= 3; i++) begin
      send(8);
      checks++;
      if (flags !== ((i == 3) ? 5'b10011 : 5'b00011) || dut.run_q !== 4'(i)) begin
        errors++;
        $display("FAIL boundary_rerun%0d got flags=%b run=%0d want %b %0d",
                 i, flags, dut.run_q, (i == 3) ? 5'b10011 : 5'b00011, i);
      end
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b0;
    #1;
    $display("mid reset flags=%b", flags);
    checks++;
    if (flags !== 5'b00000 || last_ivl !== 13'd0 || dut.state_q !== IDLE || dut.ivl !== 13'd0) begin
      errors++;
      $display("FAIL midreset_clear got flags=%b last_ivl=%0d state=%0d ivl=%0d want all 0 IDLE",
               flags, last_ivl, dut.state_q, dut.ivl);
    end
    tick();
    rst = 1'b1;
    send_first();
    checks++;
    if (flags !== 5'b00000 || last_ivl !== 13'd0 || dut.state_q !== ACQ) begin
      errors++;
      $display("FAIL midreset_ref got flags=%b last_ivl=%0d state=%0d want 00000 0 ACQ",
               flags, last_ivl, dut.state_q);
    end
    send(8);
    checks++;
    if (flags !== 5'b00010 || last_ivl !== 13'd8) begin
      errors++;
      $display("FAIL midreset_good got flags=%b last_ivl=%0d want 00010 8", flags, last_ivl);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_early();
    test_late();
    test_window();
    test_boundary();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
